mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port, byte-addressed unified memory.
- Requester I is instruction fetch (read-only). Requester D is load/store (read/write).
- Applies an alignment/bounds check to every request and returns a registered response with 1-cycle latency.
- Sits between the core front end / LSU and the memory block.

Parameters:
- DATA_W, 32, data width; must be 32.
- ADDR_W, 32, address width.
- MEM_BYTES, 16384, memory size in bytes; valid word addresses are 0..MEM_BYTES-4.
- MAX_WAIT, 4, consecutive lost arbitrations before I is forced to win; range 1..15.
- INIT_CYCLES, 2, cycles after reset release during which no grants are issued.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- i_req  in  1  I request valid.
- i_addr  in  ADDR_W  I fetch address.
- i_gnt  out  1  I request accepted this cycle (combinational).
- i_rsp_valid  out  1  I response valid (one-cycle pulse).
- i_rsp_data  out  DATA_W  I read data.
- i_rsp_err  out  1  I request was misaligned or out of range.
- d_req  in  1  D request valid.
- d_we  in  1  D request is a write (1) or a read (0).
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  D write data.
- d_gnt  out  1  D request accepted this cycle (combinational).
- d_rsp_valid  out  1  D response valid (one-cycle pulse).
- d_rsp_data  out  DATA_W  D read data; 0 for writes.
- d_rsp_err  out  1  D request was misaligned or out of range.
- mem_en  out  1  to memory: access enable.
- mem_rd_wr  out  1  to memory: 1 = read, 0 = write.
- mem_read_addr  out  ADDR_W  to memory: read address.
- mem_write_addr  out  ADDR_W  to memory: write address.
- mem_write_data  out  DATA_W  to memory: write data.
- mem_read_data  in  DATA_W  from memory: combinational read data.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to INIT; init and wait counters cleared.
  - All *_rsp_* outputs, i_gnt and d_gnt are 0.
  - mem_en=0 and mem_rd_wr=1.
  - mem_rd_wr must never be 0 except in a granted, legal D write cycle, because the memory writes on every edge where rd_wr=0.
- FSM states:
  - INIT: no grants. Stays in INIT for INIT_CYCLES rising edges after reset release, then moves to RUN.
  - RUN: one grant per cycle, at most. There is no back-pressure on responses.
- Arbitration in RUN (combinational from inputs and registered wait_cnt):
  - If both request and wait_cnt == MAX_WAIT: grant I.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
  - The requester holds req and payload until it sees gnt high. Inputs sampled while gnt is low are ignored.
- Wait counter update:
  - Incremented (saturating at MAX_WAIT) when i_req && d_gnt.
  - Cleared when i_gnt, or when i_req is low.
- Legality: a request is legal iff addr[1:0]==0 and addr <= MEM_BYTES-4.
- Memory drive in a grant cycle:
  - Legal grant: mem_en=1. mem_read_addr = granted addr. mem_rd_wr = !(D && d_we). mem_write_addr = d_addr. mem_write_data = d_wdata.
  - Illegal grant: mem_en=0, mem_rd_wr=1; no memory access occurs.
  - Non-grant cycles: mem_en=0, mem_rd_wr=1. Address and data outputs hold their last values.
- Response:
  - At the edge ending grant cycle N, register rsp_valid=1, rsp_err=!legal and rsp_data. rsp_data = mem_read_data for a legal read, otherwise 0. The response is visible in cycle N+1 for exactly one cycle.
  - A write's effect is visible to a read granted in cycle N+1 or later. Read-after-write back-to-back from D must return the new data.
- Reset asserted mid-operation: any pending response is dropped (outputs go to 0 immediately), the FSM returns to INIT and no write is issued.

Test Plan:
- Reset release, i_req=1 held with i_addr=0x0:
  - i_gnt stays 0 for 2 cycles.
  - Granted in cycle 3; i_rsp_valid in cycle 4 with data 0x00000000.
- D write 0xDEADBEEF to 0x100, then D read 0x100 on the next cycle: d_rsp_data=0xDEADBEEF, d_rsp_err=0.
- d_req and i_req both held continuously, MAX_WAIT=4:
  - Grant pattern is D,D,D,D,I repeating.
  - wait_cnt returns to 0 after each I grant.
- D write to 0x102 (misaligned), then to 0x3FFE (out of range):
  - Both get d_rsp_err=1 with mem_en=0.
  - mem_rd_wr stays 1 throughout.
  - A subsequent read of 0x100 still returns its earlier contents.
- rst pulsed low during a D write grant cycle:
  - mem_rd_wr=1 and d_rsp_valid=0 immediately.
  - The target word is not modified.
  - The block re-enters INIT for 2 cycles.
- Idle cycles with no requests: mem_en=0, mem_rd_wr=1, and both rsp_valid outputs are 0 every cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter in front of a single-port
// byte-addressed memory, with alignment/bounds checking and 1-cycle registered responses.
//
// state | meaning
// INIT  | post-reset settle, no grants for INIT_CYCLES edges
// RUN   | arbitrate, at most one grant per cycle
module mem_port_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_BYTES   = 16384,
    parameter int MAX_WAIT    = 4,
    parameter int INIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rsp_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    output logic              i_rsp_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_en,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int                INIT_CW   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_CW-1:0] INIT_LAST = INIT_CW'(INIT_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  ADDR_MAX  = ADDR_W'(MEM_BYTES - 4);
    localparam logic [3:0]         WAIT_MAX  = 4'(MAX_WAIT);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    logic [INIT_CW-1:0]  r_init_cnt;
    logic [3:0]          r_wait_cnt;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_i_rsp_valid, r_i_rsp_err, r_d_rsp_valid, r_d_rsp_err;
    logic [DATA_W-1:0]   r_i_rsp_data, r_d_rsp_data;

    logic w_run, w_force_i, w_i_gnt, w_d_gnt, w_i_legal, w_d_legal, w_legal, w_any_gnt;

    assign w_run     = (r_state == ST_RUN);
    assign w_force_i = i_req && d_req && (r_wait_cnt == WAIT_MAX);
    assign w_i_gnt   = w_run && (w_force_i || (i_req && !d_req));
    assign w_d_gnt   = w_run && d_req && !w_force_i;
    assign w_any_gnt = w_i_gnt || w_d_gnt;

    assign w_i_legal = (i_addr[1:0] == 2'b00) && (i_addr <= ADDR_MAX);
    assign w_d_legal = (d_addr[1:0] == 2'b00) && (d_addr <= ADDR_MAX);
    assign w_legal   = w_i_gnt ? w_i_legal : w_d_legal;

    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    // The memory writes on any edge with rd_wr low, so only a legal granted D write may drop it.
    assign mem_en         = w_any_gnt && w_legal;
    assign mem_rd_wr      = !(mem_en && w_d_gnt && d_we);
    assign mem_read_addr  = w_i_gnt ? i_addr : (w_d_gnt ? d_addr : r_rd_addr);
    assign mem_write_addr = w_d_gnt ? d_addr : r_wr_addr;
    assign mem_write_data = w_d_gnt ? d_wdata : r_wr_data;

    assign i_rsp_valid = r_i_rsp_valid;
    assign i_rsp_data  = r_i_rsp_data;
    assign i_rsp_err   = r_i_rsp_err;
    assign d_rsp_valid = r_d_rsp_valid;
    assign d_rsp_data  = r_d_rsp_data;
    assign d_rsp_err   = r_d_rsp_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_INIT;
            r_init_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_rd_addr     <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_i_rsp_valid <= 1'b0;
            r_i_rsp_err   <= 1'b0;
            r_i_rsp_data  <= '0;
            r_d_rsp_valid <= 1'b0;
            r_d_rsp_err   <= 1'b0;
            r_d_rsp_data  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == INIT_LAST) r_state <= ST_RUN;
                    else                         r_init_cnt <= r_init_cnt + 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase

            // Starvation guard: counts D wins while I is waiting, saturating at MAX_WAIT.
            if (!i_req || w_i_gnt)                       r_wait_cnt <= '0;
            else if (w_d_gnt && (r_wait_cnt != WAIT_MAX)) r_wait_cnt <= r_wait_cnt + 4'd1;

            r_rd_addr <= mem_read_addr;
            r_wr_addr <= mem_write_addr;
            r_wr_data <= mem_write_data;

            r_i_rsp_valid <= w_i_gnt;
            r_i_rsp_err   <= w_i_gnt && !w_i_legal;
            r_i_rsp_data  <= (w_i_gnt && w_i_legal) ? mem_read_data : '0;
            r_d_rsp_valid <= w_d_gnt;
            r_d_rsp_err   <= w_d_gnt && !w_d_legal;
            r_d_rsp_data  <= (w_d_gnt && w_d_legal && !d_we) ? mem_read_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory, scoreboard queues for both response
// ports, and one task per scenario.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rsp_valid, i_rsp_err;
    logic        d_gnt, d_rsp_valid, d_rsp_err;
    logic [31:0] i_rsp_data, d_rsp_data;
    logic        mem_en, mem_rd_wr;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
        .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, writes on every edge with rd_wr low.
    logic [31:0] mem [0:4095];
    assign mem_read_data = mem[mem_read_addr[13:2]];
    always @(posedge clk) if (mem_rd_wr === 1'b0) mem[mem_write_addr[13:2]] <= mem_write_data;

    typedef struct packed { logic [31:0] data; logic err; } rsp_t;
    rsp_t        i_q[$];
    rsp_t        d_q[$];
    logic [31:0] exp_mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    logic        prev_ig = 1'b0, prev_dg = 1'b0;

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'h3FFC);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return 32'h0;
    endfunction

    // Scoreboard monitor: response timing, payload, and write-strobe safety.
    always @(negedge clk) begin
        rsp_t e;
        if (rst === 1'b1) begin
            checks++;
            if (i_rsp_valid !== prev_ig) begin
                errors++;
                $display("FAIL i_rsp_timing got valid=%b exp %b", i_rsp_valid, prev_ig);
            end
            checks++;
            if (d_rsp_valid !== prev_dg) begin
                errors++;
                $display("FAIL d_rsp_timing got valid=%b exp %b", d_rsp_valid, prev_dg);
            end
            if (i_rsp_valid === 1'b1 && i_q.size() > 0) begin
                e = i_q.pop_front();
                checks++;
                if (i_rsp_data !== e.data || i_rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL i_rsp got data=%h err=%b exp data=%h err=%b", i_rsp_data, i_rsp_err, e.data, e.err);
                end
            end
            if (d_rsp_valid === 1'b1 && d_q.size() > 0) begin
                e = d_q.pop_front();
                checks++;
                if (d_rsp_data !== e.data || d_rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL d_rsp got data=%h err=%b exp data=%h err=%b", d_rsp_data, d_rsp_err, e.data, e.err);
                end
            end
            if (mem_rd_wr !== 1'b1) begin
                checks++;
                if (!(d_gnt === 1'b1 && d_we === 1'b1 && legal(d_addr))) begin
                    errors++;
                    $display("FAIL write_strobe got rd_wr=%b d_gnt=%b d_we=%b addr=%h exp rd_wr=1", mem_rd_wr, d_gnt, d_we, d_addr);
                end
            end
        end
        prev_ig = (i_gnt === 1'b1);
        prev_dg = (d_gnt === 1'b1);
    end

    task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bit   got = 0;
        rsp_t e;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (d_gnt === 1'b1) begin
                got = 1;
                checks++;
                if (mem_en !== legal(a) || mem_rd_wr !== !(legal(a) && we) ||
                    (legal(a) && mem_read_addr !== a)) begin
                    errors++;
                    $display("FAIL d_mem_drive addr=%h got en=%b rd_wr=%b raddr=%h exp en=%b rd_wr=%b",
                             a, mem_en, mem_rd_wr, mem_read_addr, legal(a), !(legal(a) && we));
                end
                e.err  = !legal(a);
                e.data = (legal(a) && !we) ? exp_read(a) : 32'h0;
                if (legal(a) && we) exp_mem[a] = wd;
                d_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL d_grant_timeout addr=%h got no grant exp grant within 20 cycles", a);
        end
    endtask

    task automatic i_access(input logic [31:0] a);
        bit   got = 0;
        rsp_t e;
        i_req = 1'b1; i_addr = a;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (i_gnt === 1'b1) begin
                got = 1;
                checks++;
                if (mem_en !== legal(a) || mem_rd_wr !== 1'b1 || (legal(a) && mem_read_addr !== a)) begin
                    errors++;
                    $display("FAIL i_mem_drive addr=%h got en=%b rd_wr=%b exp en=%b rd_wr=1",
                             a, mem_en, mem_rd_wr, legal(a));
                end
                e.err  = !legal(a);
                e.data = legal(a) ? exp_read(a) : 32'h0;
                i_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL i_grant_timeout addr=%h got no grant exp grant within 20 cycles", a);
        end
    endtask

    task automatic test_reset();
        rsp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b0 || d_gnt !== 1'b0 || i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 ||
            mem_en !== 1'b0 || mem_rd_wr !== 1'b1 || i_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b%b valid=%b%b en=%b rd_wr=%b exp 00 00 0 1",
                     i_gnt, d_gnt, i_rsp_valid, d_rsp_valid, mem_en, mem_rd_wr);
        end
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (i_gnt !== (c == 3)) begin
                errors++;
                $display("FAIL init_grant cycle %0d got i_gnt=%b exp %b", c, i_gnt, (c == 3));
            end
            if (c == 3) begin
                e.data = 32'h0; e.err = 1'b0;
                i_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        i_req = 1'b0;
    endtask

    task automatic test_raw();
        d_access(1'b1, 32'h100, 32'hDEADBEEF);
        d_access(1'b0, 32'h100, 32'h0);
        d_access(1'b1, 32'h104, 32'h01234567);
        d_access(1'b0, 32'h104, 32'h0);
        d_req = 1'b0;
        i_access(32'h100);
        i_req = 1'b0;
    endtask

    task automatic test_illegal();
        d_access(1'b1, 32'h102,  32'hBAD0BAD0);
        d_access(1'b1, 32'h3FFE, 32'hBAD1BAD1);
        d_access(1'b1, 32'h4000, 32'hBAD2BAD2);
        d_access(1'b0, 32'h100,  32'h0);
        d_access(1'b1, 32'h3FFC, 32'hCAFEF00D);
        d_access(1'b0, 32'h3FFC, 32'h0);
        d_req = 1'b0;
        i_access(32'h2);
        i_access(32'h3FFC);
        i_access(32'h4000);
        i_req = 1'b0;
    endtask

    // D held throughout; I request pattern includes a one-cycle drop that must clear the wait count.
    task automatic test_arbitration();
        logic [23:0] ireq_pat;
        int          wait_m = 0;
        logic        gi;
        rsp_t        e;
        ireq_pat = 24'b1111_1110_1111_1111_1111_1111;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        i_addr = 32'h104;
        for (int c = 0; c < 24; c++) begin
            i_req = ireq_pat[c];
            @(negedge clk);
            gi = ireq_pat[c] && (wait_m == 4);
            checks++;
            if (i_gnt !== gi || d_gnt !== !gi) begin
                errors++;
                $display("FAIL arb_pattern cycle %0d got i_gnt=%b d_gnt=%b exp i_gnt=%b d_gnt=%b",
                         c, i_gnt, d_gnt, gi, !gi);
            end
            e.err = 1'b0;
            if (gi) begin e.data = exp_read(32'h104); i_q.push_back(e); end
            else    begin e.data = exp_read(32'h100); d_q.push_back(e); end
            if (!ireq_pat[c] || gi) wait_m = 0;
            else if (wait_m < 4)    wait_m++;
            @(posedge clk); #1;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_idle();
        i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b0 || mem_rd_wr !== 1'b1 || i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 ||
                i_gnt !== 1'b0 || d_gnt !== 1'b0) begin
                errors++;
                $display("FAIL idle cycle %0d got en=%b rd_wr=%b valid=%b%b exp en=0 rd_wr=1 valid=00",
                         c, mem_en, mem_rd_wr, i_rsp_valid, d_rsp_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        rsp_t e;
        d_access(1'b1, 32'h200, 32'h11112222);
        d_we = 1'b0;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmid_read_grant got d_gnt=%b exp 1", d_gnt);
        end
        @(posedge clk); #1;
        d_we = 1'b1; d_wdata = 32'h33334444;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || mem_rd_wr !== 1'b0 || d_rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pre got d_gnt=%b rd_wr=%b d_rsp_valid=%b exp 1 0 1", d_gnt, mem_rd_wr, d_rsp_valid);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_rd_wr !== 1'b1 || d_rsp_valid !== 1'b0 || d_gnt !== 1'b0 || mem_en !== 1'b0 || d_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL rmid_async got rd_wr=%b d_rsp_valid=%b d_gnt=%b en=%b exp 1 0 0 0",
                     mem_rd_wr, d_rsp_valid, d_gnt, mem_en);
        end
        d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (d_gnt !== (c == 3)) begin
                errors++;
                $display("FAIL rmid_init cycle %0d got d_gnt=%b exp %b", c, d_gnt, (c == 3));
            end
            if (c == 3) begin
                e.data = exp_read(32'h200); e.err = 1'b0;
                d_q.push_back(e);
            end
            @(posedge clk); #1;
        end
        d_req = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 32'h0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        #2 rst = 1'b0;

        test_reset();
        test_raw();
        test_illegal();
        test_idle();
        test_arbitration();
        test_reset_mid();
        test_idle();

        checks++;
        if (i_q.size() != 0 || d_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got pending i=%0d d=%0d exp 0 0", i_q.size(), d_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
